vga_scan_timer: RTL and testbench

Parametrised raster timing generator for the VGA controller, the successor to the standalone vertical counter. It holds a coupled horizontal/vertical scan counter pair and derives hsync, vsync, display-enable, pixel coordinates and line/frame strobes, all with programmable timing and sync polarity. It sits between the clock/reset logic and the pixel pipeline, and it is advanced by a pixel-rate clock enable.

---
 rtl/vga_timing_pkg.sv | 18 +
 rtl/scan_axis_counter.sv | 46 ++++
 rtl/vga_scan_timer.sv | 102 ++++++++++
 tb/tb_vga_scan_timer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing defaults (640x480@60) and the per-axis total helper.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CNT_W    = 10;

    function automatic int scan_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/scan_axis_counter.sv
// One raster axis: wrapping position counter with active-region and sync-window decode.
module scan_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   ACTIVE = DEF_H_ACTIVE,
    parameter int   FP     = DEF_H_FP,
    parameter int   SYNC   = DEF_H_SYNC,
    parameter int   BP     = DEF_H_BP,
    parameter logic POL    = 1'b0,
    parameter int   W      = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    localparam int TOTAL = scan_total(ACTIVE, FP, SYNC, BP);

    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_FIRST = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_LAST  = W'(ACTIVE + FP + SYNC - 1);

    assign wrap   = inc && (count == LAST);
    assign active = (count < ACT_END);
    assign sync   = ((count >= SYNC_FIRST) && (count <= SYNC_LAST)) ? POL : ~POL;

    // clear outranks both the wrap and a plain increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_scan_timer.sv
// Raster timing generator: coupled h/v scan counters feeding a registered output stage
// that updates only on pixel-enable cycles.
module vga_scan_timer
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0,
    parameter int   CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    input  logic             restart,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);

    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             h_wrap;
    logic             v_wrap_unused;
    logic             h_active;
    logic             v_active;
    logic             h_sync;
    logic             v_sync;

    scan_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_POL),
        .W      (CNT_W)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (pix_en),
        .clear  (restart),
        .count  (h),
        .wrap   (h_wrap),
        .active (h_active),
        .sync   (h_sync)
    );

    // the vertical axis steps once per completed line
    scan_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_POL),
        .W      (CNT_W)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (h_wrap),
        .clear  (restart),
        .count  (v),
        .wrap   (v_wrap_unused),
        .active (v_active),
        .sync   (v_sync)
    );

    // outputs capture the pixel the counters are leaving; strobes last one clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                x           <= h;
                y           <= v;
                de          <= h_active && v_active;
                hsync       <= h_sync;
                vsync       <= v_sync;
                line_start  <= (h == '0);
                frame_start <= (h == '0) && (v == '0);
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_timer.sv
// Directed bench for vga_scan_timer: default 640x480 instance plus an inverted-polarity
// 1280-wide instance with a short frame so full-frame behaviour fits the run.
module tb_vga_scan_timer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        pix_en_a = 1'b0;
    logic        restart_a = 1'b0;
    logic        hsync_a, vsync_a, de_a, ls_a, fs_a;
    logic [9:0]  x_a, y_a;

    logic        pix_en_b = 1'b0;
    logic        restart_b = 1'b0;
    logic        hsync_b, vsync_b, de_b, ls_b, fs_b;
    logic [10:0] x_b, y_b;

    int checks = 0;
    int errors = 0;

    // expected output state and counter position for each instance
    int         cx_a, cy_a, cx_b, cy_b;
    logic [9:0] ex_a, ey_a;
    logic       ede_a, ehs_a, evs_a, els_a, efs_a;
    logic [10:0] ex_b, ey_b;
    logic       ede_b, ehs_b, evs_b, els_b, efs_b;

    always #5 clk = ~clk;

    vga_scan_timer dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en_a),
        .restart     (restart_a),
        .hsync       (hsync_a),
        .vsync       (vsync_a),
        .de          (de_a),
        .x           (x_a),
        .y           (y_a),
        .line_start  (ls_a),
        .frame_start (fs_a)
    );

    vga_scan_timer #(
        .H_ACTIVE (1280), .H_FP (48), .H_SYNC (112), .H_BP (248),
        .V_ACTIVE (4),    .V_FP (1),  .V_SYNC (2),   .V_BP (1),
        .H_POL    (1'b1), .V_POL (1'b1), .CNT_W (11)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en_b),
        .restart     (restart_b),
        .hsync       (hsync_b),
        .vsync       (vsync_b),
        .de          (de_b),
        .x           (x_b),
        .y           (y_b),
        .line_start  (ls_b),
        .frame_start (fs_b)
    );

    task automatic reset_model_a();
        cx_a = 0; cy_a = 0;
        ex_a = '0; ey_a = '0;
        ede_a = 1'b0; ehs_a = 1'b1; evs_a = 1'b1; els_a = 1'b0; efs_a = 1'b0;
    endtask

    task automatic reset_model_b();
        cx_b = 0; cy_b = 0;
        ex_b = '0; ey_b = '0;
        ede_b = 1'b0; ehs_b = 1'b0; evs_b = 1'b0; els_b = 1'b0; efs_b = 1'b0;
    endtask

    // driver for instance A: called at a negedge, returns at the next negedge
    task automatic tick_a(input logic en, input logic rs);
        pix_en_a = en;
        restart_a = rs;
        @(posedge clk);
        els_a = 1'b0;
        efs_a = 1'b0;
        if (en) begin
            ex_a  = 10'(cx_a);
            ey_a  = 10'(cy_a);
            ede_a = (cx_a < 640) && (cy_a < 480);
            ehs_a = !((cx_a >= 656) && (cx_a <= 751));
            evs_a = !((cy_a >= 490) && (cy_a <= 491));
            els_a = (cx_a == 0);
            efs_a = (cx_a == 0) && (cy_a == 0);
        end
        if (rs) begin
            cx_a = 0; cy_a = 0;
        end else if (en) begin
            if (cx_a == 799) begin
                cx_a = 0;
                cy_a = (cy_a == 524) ? 0 : cy_a + 1;
            end else begin
                cx_a = cx_a + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic tick_b(input logic en, input logic rs);
        pix_en_b = en;
        restart_b = rs;
        @(posedge clk);
        els_b = 1'b0;
        efs_b = 1'b0;
        if (en) begin
            ex_b  = 11'(cx_b);
            ey_b  = 11'(cy_b);
            ede_b = (cx_b < 1280) && (cy_b < 4);
            ehs_b = (cx_b >= 1328) && (cx_b <= 1439);
            evs_b = (cy_b >= 5) && (cy_b <= 6);
            els_b = (cx_b == 0);
            efs_b = (cx_b == 0) && (cy_b == 0);
        end
        if (rs) begin
            cx_b = 0; cy_b = 0;
        end else if (en) begin
            if (cx_b == 1687) begin
                cx_b = 0;
                cy_b = (cy_b == 7) ? 0 : cy_b + 1;
            end else begin
                cx_b = cx_b + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        reset_model_a();
        reset_model_b();
        repeat (2) @(negedge clk);
        checks++; if ({x_a, y_a} !== 20'd0) begin errors++; $display("FAIL reset_xy_a got x=%0d y=%0d want 0 0", x_a, y_a); end
        checks++; if (de_a !== 1'b0) begin errors++; $display("FAIL reset_de_a got %b want 0", de_a); end
        checks++; if ({hsync_a, vsync_a} !== 2'b11) begin errors++; $display("FAIL reset_sync_a got hs=%b vs=%b want 1 1", hsync_a, vsync_a); end
        checks++; if ({ls_a, fs_a} !== 2'b00) begin errors++; $display("FAIL reset_strobe_a got ls=%b fs=%b want 0 0", ls_a, fs_a); end
        checks++; if ({hsync_b, vsync_b} !== 2'b00) begin errors++; $display("FAIL reset_sync_b got hs=%b vs=%b want 0 0", hsync_b, vsync_b); end
        checks++; if ({x_b, y_b, de_b} !== 23'd0) begin errors++; $display("FAIL reset_xy_b got x=%0d y=%0d de=%b want 0 0 0", x_b, y_b, de_b); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({x_a, de_a, hsync_a, ls_a, fs_a} !== {10'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL idle_after_reset got x=%0d de=%b hs=%b ls=%b fs=%b want 0 0 1 0 0", x_a, de_a, hsync_a, ls_a, fs_a);
        end
    endtask

    task automatic test_first_pixel();
        tick_a(1'b1, 1'b0);
        checks++; if ({x_a, y_a} !== 20'd0) begin errors++; $display("FAIL first_xy got x=%0d y=%0d want 0 0", x_a, y_a); end
        checks++; if (de_a !== 1'b1) begin errors++; $display("FAIL first_de got %b want 1", de_a); end
        checks++; if ({ls_a, fs_a} !== 2'b11) begin errors++; $display("FAIL first_strobe got ls=%b fs=%b want 1 1", ls_a, fs_a); end
    endtask

    task automatic test_line_scan();
        int last_de_x = -1, hs_low = 0, hs_first = -1, ls_first = -1, ls_second = -1;
        int wrap_x = -1, wrap_y = -1, prev_x = 0;
        for (int i = 1; i <= 1700; i++) begin
            tick_a(1'b1, 1'b0);
            checks++;
            if ({x_a, y_a, de_a, hsync_a, vsync_a, ls_a, fs_a} !== {ex_a, ey_a, ede_a, ehs_a, evs_a, els_a, efs_a}) begin
                errors++;
                $display("FAIL scan_a i=%0d got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b want x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
                         i, x_a, y_a, de_a, hsync_a, vsync_a, ls_a, fs_a, ex_a, ey_a, ede_a, ehs_a, evs_a, els_a, efs_a);
            end
            if (y_a == 10'd0 && de_a) last_de_x = int'(x_a);
            if (y_a == 10'd0 && !hsync_a) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(x_a);
            end
            if (ls_a) begin
                if (ls_first < 0) ls_first = i;
                else if (ls_second < 0) ls_second = i;
            end
            if (prev_x == 799 && wrap_x < 0) begin
                wrap_x = int'(x_a);
                wrap_y = int'(y_a);
            end
            prev_x = int'(x_a);
        end
        checks++; if (last_de_x != 639) begin errors++; $display("FAIL last_de_x got %0d want 639", last_de_x); end
        checks++; if (hs_low != 96) begin errors++; $display("FAIL hsync_width got %0d want 96", hs_low); end
        checks++; if (hs_first != 656) begin errors++; $display("FAIL hsync_first_x got %0d want 656", hs_first); end
        checks++; if (ls_second - ls_first != 800) begin errors++; $display("FAIL line_period got %0d want 800", ls_second - ls_first); end
        checks++; if (wrap_x != 0 || wrap_y != 1) begin errors++; $display("FAIL line_wrap got x=%0d y=%0d want 0 1", wrap_x, wrap_y); end
    endtask

    task automatic test_pix_en_gating();
        int ls_first = -1, ls_second = -1, bad_strobe = 0;
        logic en;
        tick_a(1'b0, 1'b1);
        for (int i = 0; i < 3212; i++) begin
            en = (i % 4 == 0);
            tick_a(en, 1'b0);
            checks++;
            if ({x_a, y_a, de_a, hsync_a, vsync_a, ls_a, fs_a} !== {ex_a, ey_a, ede_a, ehs_a, evs_a, els_a, efs_a}) begin
                errors++;
                $display("FAIL gated_a i=%0d got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b want x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
                         i, x_a, y_a, de_a, hsync_a, vsync_a, ls_a, fs_a, ex_a, ey_a, ede_a, ehs_a, evs_a, els_a, efs_a);
            end
            if (!en && (ls_a || fs_a)) bad_strobe++;
            if (ls_a) begin
                if (ls_first < 0) ls_first = i;
                else if (ls_second < 0) ls_second = i;
            end
        end
        checks++; if (ls_second - ls_first != 3200) begin errors++; $display("FAIL gated_line_period got %0d want 3200", ls_second - ls_first); end
        checks++; if (bad_strobe != 0) begin errors++; $display("FAIL strobe_without_enable got %0d want 0", bad_strobe); end
    endtask

    task automatic test_restart_mid();
        tick_a(1'b0, 1'b1);
        for (int i = 0; i < 2000 && !(cx_a == 300 && cy_a == 1); i++) tick_a(1'b1, 1'b0);
        tick_a(1'b1, 1'b1);
        checks++; if ({x_a, y_a, fs_a} !== {10'd300, 10'd1, 1'b0}) begin
            errors++; $display("FAIL restart_edge got x=%0d y=%0d fs=%b want 300 1 0", x_a, y_a, fs_a);
        end
        tick_a(1'b1, 1'b0);
        checks++; if ({x_a, y_a, de_a, ls_a, fs_a} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1}) begin
            errors++; $display("FAIL restart_out got x=%0d y=%0d de=%b ls=%b fs=%b want 0 0 1 1 1", x_a, y_a, de_a, ls_a, fs_a);
        end
        tick_a(1'b1, 1'b0);
        checks++; if ({x_a, y_a, fs_a} !== {10'd1, 10'd0, 1'b0}) begin
            errors++; $display("FAIL restart_next got x=%0d y=%0d fs=%b want 1 0 0", x_a, y_a, fs_a);
        end
    endtask

    task automatic test_async_reset();
        repeat (5) tick_a(1'b1, 1'b0);
        pix_en_a = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({x_a, y_a, de_a, hsync_a, vsync_a, ls_a, fs_a} !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL async_reset got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b want 0 0 0 1 1 0 0",
                               x_a, y_a, de_a, hsync_a, vsync_a, ls_a, fs_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pix_en_a = 1'b0;
        reset_model_a();
        reset_model_b();
    endtask

    task automatic test_wide_frame();
        int fs_first = -1, fs_second = -1, fs_cnt = 0, ls_cnt = 0;
        int max_x = 0, max_y = 0, hs_high = 0, vs_min = 99, vs_max = -1;
        for (int i = 0; i < 13514; i++) begin
            tick_b(1'b1, 1'b0);
            checks++;
            if ({x_b, y_b, de_b, hsync_b, vsync_b, ls_b, fs_b} !== {ex_b, ey_b, ede_b, ehs_b, evs_b, els_b, efs_b}) begin
                errors++;
                $display("FAIL scan_b i=%0d got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b want x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
                         i, x_b, y_b, de_b, hsync_b, vsync_b, ls_b, fs_b, ex_b, ey_b, ede_b, ehs_b, evs_b, els_b, efs_b);
            end
            if (fs_b) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = i;
                else if (fs_second < 0) fs_second = i;
            end
            if (ls_b && i < 13504) ls_cnt++;
            if (int'(x_b) > max_x) max_x = int'(x_b);
            if (int'(y_b) > max_y) max_y = int'(y_b);
            if (y_b == 11'd0 && hsync_b) hs_high++;
            if (vsync_b) begin
                if (int'(y_b) < vs_min) vs_min = int'(y_b);
                if (int'(y_b) > vs_max) vs_max = int'(y_b);
            end
        end
        checks++; if (fs_cnt != 2 || fs_second - fs_first != 13504) begin
            errors++; $display("FAIL frame_period got count=%0d period=%0d want 2 13504", fs_cnt, fs_second - fs_first);
        end
        checks++; if (ls_cnt != 8) begin errors++; $display("FAIL lines_per_frame got %0d want 8", ls_cnt); end
        checks++; if (max_x != 1687 || max_y != 7) begin errors++; $display("FAIL max_xy got x=%0d y=%0d want 1687 7", max_x, max_y); end
        checks++; if (hs_high != 112) begin errors++; $display("FAIL hsync_width_b got %0d want 112", hs_high); end
        checks++; if (vs_min != 5 || vs_max != 6) begin errors++; $display("FAIL vsync_lines_b got %0d..%0d want 5..6", vs_min, vs_max); end
    endtask

    task automatic test_restart_at_wrap();
        for (int i = 0; i < 14000 && !(cx_b == 1687 && cy_b == 7); i++) tick_b(1'b1, 1'b0);
        tick_b(1'b1, 1'b1);
        checks++; if ({x_b, y_b, fs_b} !== {11'd1687, 11'd7, 1'b0}) begin
            errors++; $display("FAIL wrap_restart_edge got x=%0d y=%0d fs=%b want 1687 7 0", x_b, y_b, fs_b);
        end
        tick_b(1'b1, 1'b0);
        checks++; if ({x_b, y_b, de_b, fs_b} !== {11'd0, 11'd0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL wrap_restart_out got x=%0d y=%0d de=%b fs=%b want 0 0 1 1", x_b, y_b, de_b, fs_b);
        end
        tick_b(1'b1, 1'b0);
        checks++; if ({x_b, y_b} !== {11'd1, 11'd0}) begin
            errors++; $display("FAIL wrap_restart_next got x=%0d y=%0d want 1 0", x_b, y_b);
        end
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_line_scan();
        test_pix_en_gating();
        test_restart_mid();
        test_async_reset();
        test_wide_frame();
        test_restart_at_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
